// File: rtl/restador_serial_ctrl.sv
// Bit-serial subtractor (diff = a - b - borrow_in), one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining RESTADOR_SERIAL_OVF_EN.
module restador_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module restador_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef RESTADOR_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bout;
    logic             w_load;
    logic             w_last;
`ifdef RESTADOR_SERIAL_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    restador_1 u_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        w_load = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Results are written only on the final bit, so they hold the previous op during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_brw      <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef RESTADOR_SERIAL_OVF_EN
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else if (w_load) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_brw   <= borrow_in;
            r_cnt   <= '0;
`ifdef RESTADOR_SERIAL_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= {w_d, r_res_sh[WIDTH-1:1]};
            r_brw    <= w_bout;
            // Counter parks at zero after the last bit instead of wrapping.
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                diff       <= {w_d, r_res_sh[WIDTH-1:1]};
                borrow_out <= w_bout;
`ifdef RESTADOR_SERIAL_OVF_EN
                ovf        <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
            end
        end
    end
endmodule
